// File: rtl/qif_spike_decoder_pkg.sv
// Shared types, widths and helpers for the QIF spike decoder.
// Build option QIF_DECODER_SYNC_EN is handled in qif_edge_detect.
package qif_pkg;

  localparam int QIF_CNT_W = 16;
  localparam int QIF_SPK_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } dec_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/qif_spike_decoder_if.sv
// Result record handshake of the spike decoder.
// master drives the record, slave accepts it.
interface qif_spike_decoder_if #(
  parameter int CNT_W = 16,
  parameter int SPK_W = 8
);

  logic             out_valid;
  logic             out_ready;
  logic [SPK_W-1:0] out_count;
  logic [CNT_W-1:0] out_isi;
  logic             out_overrun;

  modport master (
    output out_valid,
    output out_count,
    output out_isi,
    output out_overrun,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_isi,
    input  out_overrun,
    output out_ready
  );

endinterface

// File: rtl/qif_spike_decoder_edge_detect.sv
// Rising-edge pulse from the spike level.
// QIF_DECODER_SYNC_EN adds a two-flop synchronizer in front.
module qif_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_spike,
  output logic o_edge
);

  logic w_spk;
  logic r_prev;

`ifdef QIF_DECODER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], i_spike};
  end

  assign w_spk = r_sync[1];
`else
  assign w_spk = i_spike;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_spk;
  end

  assign o_edge = w_spk & ~r_prev;

endmodule

// File: rtl/qif_spike_decoder.sv
// Spike counter and ISI meter over programmable windows.
// One result record per window on a valid/ready port.
module qif_spike_decoder
  import qif_pkg::*;
#(
  parameter int CNT_W = QIF_CNT_W,
  parameter int SPK_W = QIF_SPK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [CNT_W-1:0] win_len,
  qif_spike_decoder_if.master o_rec
);

  localparam logic [31:0] CNT_MAX =
    {{(32-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [31:0] SPK_MAX =
    {{(32-SPK_W){1'b0}}, {SPK_W{1'b1}}};
  localparam logic [CNT_W-1:0] ONE_C = 1;

  dec_state_t       r_state;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_win_len_q;
  logic [CNT_W-1:0] r_isi_cnt;
  logic [CNT_W-1:0] r_last_isi;
  logic [SPK_W-1:0] r_spk_cnt;

  logic             w_edge;
  logic             w_term;
  logic             w_accept;
  logic [SPK_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_isi_nx;
  logic [CNT_W-1:0] w_isi_inc;

  qif_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_spike (spike_in),
    .o_edge  (w_edge)
  );

  assign w_term = (r_state != IDLE) &&
                  (r_win_cnt == r_win_len_q - ONE_C);
  assign w_accept = o_rec.out_valid & o_rec.out_ready;
  assign w_cnt_nx = w_edge
    ? SPK_W'(sat_inc(32'(r_spk_cnt), SPK_MAX))
    : r_spk_cnt;
  // a spike on the terminal cycle still lands in the closing record
  assign w_isi_nx = (w_edge && r_state == RUN)
    ? r_isi_cnt : r_last_isi;
  assign w_isi_inc = CNT_W'(sat_inc(32'(r_isi_cnt), CNT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_win_cnt         <= '0;
      r_win_len_q       <= '0;
      r_isi_cnt         <= '0;
      r_last_isi        <= '0;
      r_spk_cnt         <= '0;
      o_rec.out_valid   <= 1'b0;
      o_rec.out_count   <= '0;
      o_rec.out_isi     <= '0;
      o_rec.out_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        o_rec.out_valid   <= 1'b0;
        o_rec.out_overrun <= 1'b0;
      end
      if (enable && w_term) begin
        if (!o_rec.out_valid || w_accept) begin
          o_rec.out_valid   <= 1'b1;
          o_rec.out_count   <= w_cnt_nx;
          o_rec.out_isi     <= w_isi_nx;
          o_rec.out_overrun <= 1'b0;
        end else begin
          o_rec.out_overrun <= 1'b1;
        end
      end

      if (!enable) begin
        r_state    <= IDLE;
        r_win_cnt  <= '0;
        r_isi_cnt  <= '0;
        r_last_isi <= '0;
        r_spk_cnt  <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (win_len != '0) begin
              r_state     <= ARMED;
              r_win_len_q <= win_len;
              r_win_cnt   <= '0;
            end
          end
          ARMED, RUN: begin
            r_isi_cnt <= w_edge ? ONE_C : w_isi_inc;
            if (w_edge) r_state <= RUN;
            if (w_term) begin
              r_win_cnt   <= '0;
              r_spk_cnt   <= '0;
              r_last_isi  <= '0;
              r_win_len_q <= win_len;
              if (win_len == '0) begin
                r_state   <= IDLE;
                r_isi_cnt <= '0;
              end
            end else begin
              r_win_cnt  <= r_win_cnt + ONE_C;
              r_spk_cnt  <= w_cnt_nx;
              r_last_isi <= w_isi_nx;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Directed bench for qif_spike_decoder.
// Window cycle i is the i-th clock after arming.
module tb_qif_spike_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        spike_in = 1'b0;
  logic [15:0] win_len = '0;

  int total = 0;
  int bad = 0;

  qif_spike_decoder_if #(.CNT_W(16), .SPK_W(8)) rec ();

  qif_spike_decoder #(.CNT_W(16), .SPK_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .spike_in (spike_in),
    .win_len  (win_len),
    .o_rec    (rec)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int len);
    enable        = 1'b0;
    spike_in      = 1'b0;
    rec.out_ready = 1'b1;
    step();
    rec.out_ready = 1'b0;
    win_len       = 16'(len);
    enable        = 1'b1;
    step();
  endtask

  task automatic win(
    input int n, input int a, input int b, input int c,
    input int hs, input int he, input int acc
  );
    for (int i = 0; i < n; i++) begin
      spike_in = (i == a) || (i == b) || (i == c) ||
                 (i >= hs && i <= he);
      rec.out_ready = (i == acc);
      step();
    end
    spike_in      = 1'b0;
    rec.out_ready = 1'b0;
  endtask

  task automatic chk_rec(
    input string tag, input int v, input int cnt,
    input int isi, input int ovr
  );
    chk({tag, ".valid"}, 32'(rec.out_valid), 32'(v));
    chk({tag, ".count"}, 32'(rec.out_count), 32'(cnt));
    chk({tag, ".isi"}, 32'(rec.out_isi), 32'(isi));
    chk({tag, ".ovr"}, 32'(rec.out_overrun), 32'(ovr));
  endtask

  initial begin
    rec.out_ready = 1'b0;
    #12;
    chk_rec("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // basic ISI
    arm(100);
    win(100, 10, 30, 55, -1, -1, -1);
    chk_rec("basic", 1, 3, 25, 0);
    step();
    chk_rec("hold", 1, 3, 25, 0);
    rec.out_ready = 1'b1;
    step();
    rec.out_ready = 1'b0;
    chk("basic.acc", 32'(rec.out_valid), 32'd0);

    // single spike, ISI across windows, terminal spike
    arm(50);
    win(50, 5, -1, -1, -1, -1, -1);
    chk_rec("single", 1, 1, 0, 0);
    win(50, 15, -1, -1, -1, -1, 0);
    chk_rec("span", 1, 1, 60, 0);
    win(50, 20, 49, -1, -1, -1, 0);
    chk_rec("term", 1, 2, 29, 0);

    // held high
    arm(50);
    win(50, -1, -1, -1, 3, 12, -1);
    chk_rec("held", 1, 1, 0, 0);

    // backpressure and overrun
    arm(20);
    win(20, 2, -1, -1, -1, -1, -1);
    chk_rec("bp.w1", 1, 1, 0, 0);
    win(20, 2, 5, -1, -1, -1, -1);
    chk_rec("bp.w2", 1, 1, 0, 1);
    win(20, 7, -1, -1, -1, -1, 19);
    chk_rec("bp.w3", 1, 1, 22, 0);
    win(20, -1, -1, -1, -1, -1, -1);
    chk_rec("bp.w4", 1, 1, 22, 1);
    win(20, -1, -1, -1, -1, -1, 0);
    chk_rec("bp.w5", 1, 0, 0, 0);

    // count saturation
    arm(1000);
    for (int i = 0; i < 1000; i++) begin
      spike_in = (i % 2 == 0);
      step();
    end
    spike_in = 1'b0;
    chk("sat.count", 32'(rec.out_count), 32'd255);
    chk("sat.isi", 32'(rec.out_isi), 32'd2);

    // ISI saturation
    arm(33001);
    win(33001, 0, -1, -1, -1, -1, -1);
    chk_rec("isisat.w1", 1, 1, 0, 0);
    win(33001, 32999, -1, -1, -1, -1, 0);
    chk_rec("isisat.w2", 1, 1, 65535, 0);

    // win_len 0 never runs
    arm(0);
    win(200, 5, 50, 150, -1, -1, -1);
    chk("zero.valid", 32'(rec.out_valid), 32'd0);

    // reset mid-window
    arm(20);
    win(20, 3, -1, -1, -1, -1, -1);
    chk_rec("prerst", 1, 1, 0, 0);
    win(10, 4, -1, -1, -1, -1, -1);
    #2 rst = 1'b1;
    #1;
    chk_rec("rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rst.nopart", 32'(rec.out_valid), 32'd0);

    // enable drop with pending record
    arm(20);
    win(20, 4, -1, -1, -1, -1, -1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("en.held.v", 32'(rec.out_valid), 32'd1);
    chk("en.held.c", 32'(rec.out_count), 32'd1);
    rec.out_ready = 1'b1;
    step();
    rec.out_ready = 1'b0;
    chk("en.acc", 32'(rec.out_valid), 32'd0);
    win(30, 3, 9, -1, -1, -1, -1);
    chk("en.idle", 32'(rec.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qif_spike_decoder.md
# qif_spike_decoder

Receive-side companion to the 8-bit QIF neuron. Takes the neuron's spike output in the same clock domain, counts spikes over a programmable window and measures the inter-spike interval (ISI) in clock cycles. Once per window it presents a result record on a valid/ready output. Used on-chip for rate readout and by the bench as a reference spike monitor.

## Interface
- `CNT_W`, 16: width of the ISI counter and of `win_len`.
- `SPK_W`, 8: width of the per-window spike count.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run the decoder; 0 returns it to IDLE.
- `spike_in` in 1: neuron spike output, level; each 0→1 transition is one spike.
- `win_len` in CNT_W: window length in cycles; sampled when a window starts; 0 is not allowed to run (decoder stays IDLE).
- `out_valid` out 1: result record is available.
- `out_ready` in 1: consumer accepts the record.
- `out_count` out SPK_W: spikes seen in the window, saturating.
- `out_isi` out CNT_W: most recent ISI completed in the window; 0 if none.
- `out_overrun` out 1: at least one window result was dropped since the last accepted record.

## Operation
- Edge detect: `spike_edge = spike_in & ~spike_prev`. `spike_prev` is a register, reset to 0.
- States:
  - IDLE: counters cleared.
  - ARMED: running, no spike seen since enable, so ISI is invalid.
  - RUN: ISI counter valid.
- Transitions:
  - IDLE→ARMED when `enable=1` and `win_len≠0`.
  - ARMED→RUN on the first `spike_edge`.
  - Any state→IDLE when `enable=0`.
- ISI counter `isi_cnt`: set to 1 on `spike_edge`; otherwise +1, saturating at 2^CNT_W−1.
  - On `spike_edge` in RUN: `last_isi <= isi_cnt`. Edges at cycles t and t+5 give ISI=5.
- Window counter: counts 0..`win_len_q`−1. `win_len_q` is sampled at every window start.
  - On the terminal cycle the window closes.
  - `spike_count` increments on `spike_edge`, saturating at 2^SPK_W−1.
  - A spike on the terminal cycle belongs to the closing window.
- Window close:
  - If the output register is empty, or is being accepted this cycle, load `{count, last_isi}` and set `out_valid`.
  - Otherwise drop the record and set the sticky overrun flag.
  - `spike_count` and `last_isi` clear and the next window starts on the following cycle. `isi_cnt` is not cleared, so an ISI may span windows.
- Handshake: the record transfers on a cycle with `out_valid & out_ready`.
  - `out_*` stay stable while `out_valid=1` and `out_ready=0`.
  - `out_overrun` is part of the record and clears on transfer.
  - If a drop happens in the same cycle as a transfer, the new record loads and overrun=0.
- `enable` deassert: internal counters clear; a pending output record is held until accepted.

## Timing
- Reset values: `out_valid=0`, `out_count=0`, `out_isi=0`, `out_overrun=0`; state IDLE; all counters 0.
- Edge-to-count latency: 0 cycles. The counter updates on the clock edge where `spike_in=1` and `spike_prev=0`.
- Window close to `out_valid`: 1 cycle. `out_valid` rises the cycle after the terminal window cycle.
- Window period is exactly `win_len_q` cycles; no dead cycle between windows.
- Reset asserted mid-window: all state clears immediately and no partial record is emitted.
- `spike_in` held high: one spike only; the next spike needs a return to 0.

## Configuration
- `QIF_DECODER_SYNC_EN`
  - Defined: `spike_in` passes through a two-flop synchronizer, reset to 0, before edge detection. Edge-to-count latency becomes 2 cycles. Use when the spike source is asynchronous, e.g. a pad.
  - Undefined: `spike_in` is used directly; latency 0.

## Structure
- Shared package `qif_pkg`:
  - state enum `dec_state_t` {IDLE, ARMED, RUN};
  - default widths `QIF_CNT_W=16`, `QIF_SPK_W=8`;
  - saturating-increment helper function.
- One sub-module, `qif_edge_detect`: optional synchronizer plus rising-edge pulse.
- Counters, FSM and output register stay in the top block.

## Test plan
- Basic ISI: win_len=100; spikes at cycles 10, 30, 55 of the window → record count=3, isi=25, overrun=0.
- Single spike: win_len=50, one spike → count=1, isi=0. Next window, spike 60 cycles after the first → isi=60 (ISI spans windows).
- Saturation: win_len=1000, spikes every 2 cycles (~500 edges) → count=255. No spikes for 70000 cycles, then a spike → isi=65535.
- Backpressure/overrun: win_len=20, `out_ready=0` for 3 windows → first record held stable; overrun=1 on that record, cleared after accept. The third-window record loads only if accepted in the same cycle as the close.
- Boundaries:
  - spike on the terminal window cycle → counted in the closing window;
  - `spike_in` held high for 10 cycles → count=1;
  - win_len=0 → stays IDLE, no `out_valid`.
- Reset/enable: assert `rst` mid-window → all outputs 0 next cycle. Drop `enable` with a pending record → record retained until `out_ready`, then state IDLE. With `QIF_DECODER_SYNC_EN`, count updates 2 cycles after `spike_in` rises.
